axis_pkt_receiver: RTL and testbench
====================================

// Module: axis_pkt_receiver
// PURPOSE
//  AXI4-Stream receiving end (Slave modport of axi4_stream_if). Accepts
//  packets, writes each beat into a word-addressed buffer via a simple
//  write port, and reports per-packet byte length, TID, TDEST and an error
//  flag. Sits between any stream source and a packet RAM or CPU-visible buffer.
// PARAMETERS
//  TDATA_W  32  stream data width, multiple of 8
//  TID_W    1   TID width
//  TDEST_W  1   TDEST width
//  TUSER_W  1   TUSER width (not used)
//  ADDR_W   10  buffer word-address width; max 2**ADDR_W beats per packet
//  LEN_W    16  byte-length counter width
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          async reset, active low
//  s_axis     --   if         axi4_stream_if.Slave (tvalid..tuser)
//  wr_en      out  1          buffer write strobe
//  wr_addr    out  ADDR_W     beat index within packet, 0-based
//  wr_data    out  TDATA_W    tdata of the accepted beat
//  wr_strb    out  TDATA_W/8  tkeep & tstrb of the accepted beat
//  wr_ready   in   1          buffer can take a write this cycle
//  pkt_done   out  1          1-cycle pulse: packet complete
//  pkt_len    out  LEN_W      byte count (popcount tkeep), valid from pkt_done
//  pkt_id     out  TID_W      TID of first beat
//  pkt_dest   out  TDEST_W    TDEST of first beat
//  pkt_err    out  1          packet error flag, valid from pkt_done
// BEHAVIOUR
//  Clock clk; reset rst_n asynchronous, active low.
//  Beat accepted = tvalid & tready on rising clk.
//  Reset: state IDLE; beat/byte counters 0; pkt_done, pkt_len, pkt_id,
//   pkt_dest, pkt_err = 0. tready = 0 and wr_en = 0 while rst_n low.
//  FSM states: IDLE, RECV, DRAIN, DONE.
//   IDLE : tready = wr_ready. Accepted beat: capture tid/tdest, write it
//          at addr 0. Go to DONE if tlast, else RECV.
//   RECV : tready = wr_ready. Each accepted beat writes at the next addr.
//          tlast -> DONE. Beat count reaching 2**ADDR_W without tlast ->
//          DRAIN with err set.
//   DRAIN: tready = 1, wr_en = 0. Beats are discarded until tlast -> DONE.
//   DONE : tready = 0 for exactly one cycle; pkt_done = 1; then IDLE.
//  Write path is combinational, zero latency: wr_en = accepted beat &
//   state != DRAIN; wr_data = tdata; wr_strb = tkeep & tstrb.
//  tready never depends on tvalid. tvalid held without tready is legal.
//  Length: pkt_len = sum of popcount(tkeep) over all accepted beats,
//   including DRAIN beats. Saturates at 2**LEN_W-1 and sets err.
//   Null beats (tkeep = 0) are written but add 0 bytes.
//  pkt_err is set on any of:
//   - non-last beat with tkeep not all-ones
//   - tid or tdest differs from the first beat
//   - buffer overflow (DRAIN)
//   - length saturation
//  pkt_len, pkt_id, pkt_dest, pkt_err are registered. They update on
//   entry to DONE and hold until the next DONE.
//  Working counters clear on the IDLE->RECV/DONE transition.
//  Reset mid-packet: packet abandoned, no pkt_done, restart in IDLE.
//  tuser is ignored.
// TESTING
//  1. 3-beat packet, tkeep all-ones, wr_ready = 1 -> wr_addr 0,1,2;
//     pkt_done 1 cycle after last beat; pkt_len = 12; pkt_err = 0.
//  2. Single beat with tlast, tkeep = 4'b0011 -> one write, pkt_len = 2,
//     tready low during the DONE cycle.
//  3. wr_ready toggled 1/0 during a 4-beat packet, tvalid held ->
//     tready tracks wr_ready, no beat lost or duplicated, pkt_len = 16.
//  4. ADDR_W = 2, 6-beat packet -> 4 writes, 2 beats drained,
//     pkt_len = 24, pkt_err = 1.
//  5. tdest changes on beat 2, or non-last beat has tkeep = 4'b0111
//     -> pkt_err = 1, all beats still written.
//  6. rst_n asserted mid-packet -> tready = 0 immediately, no pkt_done;
//     next packet starts at wr_addr 0 with fresh pkt_len.

Source files
------------

// File: rtl/axis_pkt_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_receiver
//  Description : AXI4-Stream packet sink. Each accepted beat goes straight out
//                through a zero-latency buffer write port, addressed by its
//                beat index within the packet. When a packet ends, it reports
//                the byte length, the TID/TDEST of the first beat and an
//                error flag.
//  Ports       : clk, rst_n            clock, async active-low reset
//                s_axis_t*             stream slave (tuser is ignored)
//                wr_en/addr/data/strb  buffer write port, wr_ready = can write
//                pkt_done              1-cycle pulse while in DONE
//                pkt_len/id/dest/err   packet report, valid from pkt_done
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_receiver #(
    parameter int TDATA_W = 32,
    parameter int TID_W   = 1,
    parameter int TDEST_W = 1,
    parameter int TUSER_W = 1,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [TDATA_W-1:0]   s_axis_tdata,
    input  logic [TDATA_W/8-1:0] s_axis_tkeep,
    input  logic [TDATA_W/8-1:0] s_axis_tstrb,
    input  logic                 s_axis_tlast,
    input  logic [TID_W-1:0]     s_axis_tid,
    input  logic [TDEST_W-1:0]   s_axis_tdest,
    input  logic [TUSER_W-1:0]   s_axis_tuser,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [TDATA_W-1:0]   wr_data,
    output logic [TDATA_W/8-1:0] wr_strb,
    input  logic                 wr_ready,
    output logic                 pkt_done,
    output logic [LEN_W-1:0]     pkt_len,
    output logic [TID_W-1:0]     pkt_id,
    output logic [TDEST_W-1:0]   pkt_dest,
    output logic                 pkt_err
);

    localparam int KEEP_W = TDATA_W / 8;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  C_MAX_BEATS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LEN_W-1:0]  C_LEN_MAX   = '1;
    localparam logic [KEEP_W-1:0] C_KEEP_FULL = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [CNT_W-1:0]     r_beat_cnt;
    logic [LEN_W-1:0]     r_byte_cnt;
    logic                 r_err;
    logic [TID_W-1:0]     r_tid;
    logic [TDEST_W-1:0]   r_tdest;
    logic [LEN_W-1:0]     r_pkt_len;
    logic [TID_W-1:0]     r_pkt_id;
    logic [TDEST_W-1:0]   r_pkt_dest;
    logic                 r_pkt_err;

    logic                 w_first;
    logic                 w_tready;
    logic                 w_accept;
    logic [CNT_W-1:0]     w_beat_base;
    logic [CNT_W-1:0]     w_beat_inc;
    logic [LEN_W-1:0]     w_byte_base;
    logic [LEN_W:0]       w_byte_sum;
    logic                 w_sat;
    logic [LEN_W-1:0]     w_byte_nxt;
    logic [TID_W-1:0]     w_ref_tid;
    logic [TDEST_W-1:0]   w_ref_tdest;
    logic                 w_overflow;
    logic                 w_beat_err;
    logic                 w_err_nxt;
    logic                 w_unused;

    function automatic logic [LEN_W:0] f_popcount(input logic [KEEP_W-1:0] keep);
        logic [LEN_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            cnt = cnt + {{LEN_W{1'b0}}, keep[i]};
        end
        return cnt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // In IDLE the working counters are treated as zero, so the first beat
        // of a packet starts fresh without needing an extra clear cycle.
        w_first     = (r_state == S_IDLE);
        w_beat_base = w_first ? '0 : r_beat_cnt;
        w_byte_base = w_first ? '0 : r_byte_cnt;
        w_ref_tid   = w_first ? s_axis_tid   : r_tid;
        w_ref_tdest = w_first ? s_axis_tdest : r_tdest;
        w_beat_inc  = w_beat_base + {{ADDR_W{1'b0}}, 1'b1};

        w_tready    = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RECV: w_tready = wr_ready;
            S_DRAIN:        w_tready = 1'b1;
            S_DONE:         w_tready = 1'b0;
            default:        w_tready = 1'b0;
        endcase
        // Registers reset asynchronously to IDLE, where tready would follow
        // wr_ready; gating with rst_n keeps the stream stalled during reset.
        w_tready = w_tready & rst_n;
        w_accept = s_axis_tvalid & w_tready;

        w_byte_sum = {1'b0, w_byte_base} + f_popcount(s_axis_tkeep);
        w_sat      = w_byte_sum[LEN_W];
        w_byte_nxt = w_sat ? C_LEN_MAX : w_byte_sum[LEN_W-1:0];

        // Last buffer slot just written and the packet goes on: drain the rest.
        w_overflow = ~s_axis_tlast & (r_state != S_DRAIN) & (w_beat_inc == C_MAX_BEATS);
        w_beat_err = (~s_axis_tlast & (s_axis_tkeep != C_KEEP_FULL))
                   | (s_axis_tid   != w_ref_tid)
                   | (s_axis_tdest != w_ref_tdest);
        w_err_nxt  = (~w_first & r_err) | w_beat_err | w_sat | w_overflow;

        case (r_state)
            S_IDLE, S_RECV: begin
                if (w_accept) begin
                    if (s_axis_tlast) begin
                        w_state_nxt = S_DONE;
                    end else if (w_overflow) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_RECV;
                    end
                end
            end
            S_DRAIN: begin
                if (w_accept && s_axis_tlast) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_byte_cnt <= '0;
            r_err      <= 1'b0;
            r_tid      <= '0;
            r_tdest    <= '0;
            r_pkt_len  <= '0;
            r_pkt_id   <= '0;
            r_pkt_dest <= '0;
            r_pkt_err  <= 1'b0;
        end else if (w_accept) begin
            if (r_state != S_DRAIN) begin
                r_beat_cnt <= w_beat_inc;
            end
            r_byte_cnt <= w_byte_nxt;
            r_err      <= w_err_nxt;
            if (w_first) begin
                r_tid   <= s_axis_tid;
                r_tdest <= s_axis_tdest;
            end
            // Report registers load on the beat that enters DONE.
            if (s_axis_tlast) begin
                r_pkt_len  <= w_byte_nxt;
                r_pkt_id   <= w_ref_tid;
                r_pkt_dest <= w_ref_tdest;
                r_pkt_err  <= w_err_nxt;
            end
        end
    end

    assign s_axis_tready = w_tready;
    assign wr_en         = w_accept & (r_state != S_DRAIN);
    assign wr_addr       = w_beat_base[ADDR_W-1:0];
    assign wr_data       = s_axis_tdata;
    assign wr_strb       = s_axis_tkeep & s_axis_tstrb;
    assign pkt_done      = (r_state == S_DONE);
    assign pkt_len       = r_pkt_len;
    assign pkt_id        = r_pkt_id;
    assign pkt_dest      = r_pkt_dest;
    assign pkt_err       = r_pkt_err;
    assign w_unused      = ^s_axis_tuser;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_axis_pkt_receiver
//  Description : Self-checking bench for axis_pkt_receiver (ADDR_W=2, LEN_W=6
//                so buffer overflow and length saturation are reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_receiver;

    localparam int TDATA_W = 32;
    localparam int ADDR_W  = 2;
    localparam int LEN_W   = 6;
    localparam int MAXB    = 1 << ADDR_W;
    localparam int LENMAX  = (1 << LEN_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic [31:0]       s_axis_tdata = '0;
    logic [3:0]        s_axis_tkeep = '0;
    logic [3:0]        s_axis_tstrb = '0;
    logic              s_axis_tlast = 1'b0;
    logic [0:0]        s_axis_tid = '0;
    logic [0:0]        s_axis_tdest = '0;
    logic [0:0]        s_axis_tuser = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_ready = 1'b1;
    logic              pkt_done;
    logic [LEN_W-1:0]  pkt_len;
    logic [0:0]        pkt_id;
    logic [0:0]        pkt_dest;
    logic              pkt_err;

    axis_pkt_receiver #(
        .TDATA_W(TDATA_W), .TID_W(1), .TDEST_W(1), .TUSER_W(1),
        .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
        .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest),
        .s_axis_tuser(s_axis_tuser),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_ready(wr_ready),
        .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_id(pkt_id),
        .pkt_dest(pkt_dest), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Packet under test
    int          nb;
    logic [31:0] bdata [32];
    logic [3:0]  bkeep [32];
    logic [3:0]  bstrb [32];
    logic        btid  [32];
    logic        bdest [32];

    // Observations
    int          got_addr [$];
    logic [31:0] got_data [$];
    logic [3:0]  got_strb [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_hs_cyc = 0;
    int          done_tready_bad = 0;
    int          track_bad = 0;
    logic [LEN_W-1:0] o_len = '0;
    logic        o_id = 1'b0;
    logic        o_dest = 1'b0;
    logic        o_err = 1'b0;

    // Reference results
    int          e_nwr;
    int          e_len;
    logic        e_err;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_en) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(wr_data);
            got_strb.push_back(wr_strb);
        end
        if (pkt_done) begin
            done_cnt++;
            done_cyc = cyc;
            o_len  = pkt_len;
            o_id   = pkt_id[0];
            o_dest = pkt_dest[0];
            o_err  = pkt_err;
            if (s_axis_tready) done_tready_bad++;
        end
    end

    // Reference: what the receiver must report for the packet in b*[0:nb-1].
    task automatic model_pkt();
        int sum;
        sum   = 0;
        e_err = 1'b0;
        for (int i = 0; i < nb; i++) begin
            sum += $countones(bkeep[i]);
            if (i < nb - 1 && bkeep[i] != 4'hF) e_err = 1'b1;
            if (btid[i] != btid[0] || bdest[i] != bdest[0]) e_err = 1'b1;
        end
        if (nb > MAXB) e_err = 1'b1;
        e_nwr = (nb > MAXB) ? MAXB : nb;
        if (sum > LENMAX) begin
            e_len = LENMAX;
            e_err = 1'b1;
        end else begin
            e_len = sum;
        end
    endtask

    task automatic fill_pkt(input int n, input logic tid, input logic dest);
        nb = n;
        for (int i = 0; i < n; i++) begin
            bdata[i] = $urandom;
            bkeep[i] = 4'hF;
            bstrb[i] = 4'hF;
            btid[i]  = tid;
            bdest[i] = dest;
        end
    endtask

    // mode 0: wr_ready high, 1: wr_ready toggles, 2: random ready and gaps
    task automatic run_packet(input int mode, output logic timed_out);
        int   start;
        int   waited;
        logic hs;
        timed_out = 1'b0;
        got_addr.delete();
        got_data.delete();
        got_strb.delete();
        track_bad = 0;
        start = done_cnt;
        for (int i = 0; i < nb; i++) begin
            if (mode == 2) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    wr_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = bdata[i];
            s_axis_tkeep  = bkeep[i];
            s_axis_tstrb  = bstrb[i];
            s_axis_tid    = btid[i];
            s_axis_tdest  = bdest[i];
            s_axis_tuser  = 1'($urandom_range(0, 1));
            s_axis_tlast  = (i == nb - 1);
            hs = 1'b0;
            waited = 0;
            while (!hs && !timed_out) begin
                case (mode)
                    0:       wr_ready = 1'b1;
                    1:       wr_ready = ~wr_ready;
                    default: wr_ready = ($urandom_range(0, 3) != 0);
                endcase
                @(negedge clk);
                hs = s_axis_tvalid && s_axis_tready;
                if (s_axis_tready !== wr_ready) track_bad++;
                if (hs) last_hs_cyc = cyc;
                @(posedge clk); #1;
                waited++;
                if (waited > 100) timed_out = 1'b1;
            end
            if (timed_out) break;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        waited = 0;
        while (done_cnt == start && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (done_cnt == start) timed_out = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        s_axis_tvalid = 1'b1;
        wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (s_axis_tready !== 1'b0 || wr_en !== 1'b0) begin
            bad++; $display("FAIL reset_ready tready=%b wr_en=%b want 0 0", s_axis_tready, wr_en);
        end
        total++;
        if (pkt_done !== 1'b0 || pkt_len !== '0 || pkt_err !== 1'b0 || pkt_id !== '0 || pkt_dest !== '0) begin
            bad++; $display("FAIL reset_outputs done=%b len=%0d err=%b id=%b dest=%b want all 0",
                            pkt_done, pkt_len, pkt_err, pkt_id, pkt_dest);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_three_beat();
        logic tmo;
        fill_pkt(3, 1'b1, 1'b0);
        model_pkt();
        run_packet(0, tmo);
        total++;
        if (tmo !== 1'b0) begin bad++; $display("FAIL three_timeout got=%b want=0", tmo); end
        total++;
        if (got_addr.size() != 3) begin bad++; $display("FAIL three_nwr got=%0d want=3", got_addr.size()); end
        for (int i = 0; i < got_addr.size() && i < 3; i++) begin
            total++;
            if (got_addr[i] != i || got_data[i] !== bdata[i]) begin
                bad++; $display("FAIL three_write%0d addr=%0d data=%h want addr=%0d data=%h",
                                i, got_addr[i], got_data[i], i, bdata[i]);
            end
        end
        total++;
        if (done_cyc != last_hs_cyc + 1) begin
            bad++; $display("FAIL three_done_latency got=%0d want=%0d", done_cyc - last_hs_cyc, 1);
        end
        total++;
        if (int'(o_len) != 12 || o_err !== 1'b0 || o_id !== 1'b1 || o_dest !== 1'b0) begin
            bad++; $display("FAIL three_report len=%0d err=%b id=%b dest=%b want 12 0 1 0",
                            o_len, o_err, o_id, o_dest);
        end
    endtask

    task automatic test_single_beat();
        logic tmo;
        int   start;
        fill_pkt(1, 1'b0, 1'b1);
        bkeep[0] = 4'b0011;
        bstrb[0] = 4'b0111;
        done_tready_bad = 0;
        start = done_cnt;
        run_packet(0, tmo);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (tmo !== 1'b0 || got_addr.size() != 1) begin
            bad++; $display("FAIL single_nwr got=%0d timeout=%b want 1 0", got_addr.size(), tmo);
        end else begin
            total++;
            if (got_addr[0] != 0 || got_strb[0] !== 4'b0011) begin
                bad++; $display("FAIL single_write addr=%0d strb=%b want 0 0011", got_addr[0], got_strb[0]);
            end
        end
        total++;
        if (int'(o_len) != 2 || o_err !== 1'b0) begin
            bad++; $display("FAIL single_report len=%0d err=%b want 2 0", o_len, o_err);
        end
        total++;
        if (done_tready_bad != 0) begin
            bad++; $display("FAIL single_done_tready got=%0d high cycles want=0", done_tready_bad);
        end
        total++;
        if (done_cnt != start + 1) begin
            bad++; $display("FAIL single_done_pulses got=%0d want=1", done_cnt - start);
        end
    endtask

    task automatic test_backpressure();
        logic tmo;
        fill_pkt(4, 1'b0, 1'b0);
        wr_ready = 1'b1;
        run_packet(1, tmo);
        total++;
        if (tmo !== 1'b0 || got_addr.size() != 4) begin
            bad++; $display("FAIL bp_nwr got=%0d timeout=%b want 4 0", got_addr.size(), tmo);
        end
        for (int i = 0; i < got_addr.size() && i < 4; i++) begin
            total++;
            if (got_addr[i] != i || got_data[i] !== bdata[i]) begin
                bad++; $display("FAIL bp_write%0d addr=%0d data=%h want addr=%0d data=%h",
                                i, got_addr[i], got_data[i], i, bdata[i]);
            end
        end
        total++;
        if (track_bad != 0) begin bad++; $display("FAIL bp_tready_track got=%0d diffs want=0", track_bad); end
        total++;
        if (int'(o_len) != 16 || o_err !== 1'b0) begin
            bad++; $display("FAIL bp_report len=%0d err=%b want 16 0", o_len, o_err);
        end
    endtask

    task automatic test_overflow();
        logic tmo;
        fill_pkt(6, 1'b1, 1'b1);
        run_packet(0, tmo);
        total++;
        if (tmo !== 1'b0 || got_addr.size() != 4) begin
            bad++; $display("FAIL ovf_nwr got=%0d timeout=%b want 4 0", got_addr.size(), tmo);
        end
        total++;
        if (int'(o_len) != 24 || o_err !== 1'b1) begin
            bad++; $display("FAIL ovf_report len=%0d err=%b want 24 1", o_len, o_err);
        end
        fill_pkt(16, 1'b0, 1'b0);
        run_packet(0, tmo);
        total++;
        if (tmo !== 1'b0 || int'(o_len) != LENMAX || o_err !== 1'b1) begin
            bad++; $display("FAIL sat_report len=%0d err=%b timeout=%b want %0d 1 0", o_len, o_err, tmo, LENMAX);
        end
    endtask

    task automatic test_errors();
        logic tmo;
        fill_pkt(3, 1'b0, 1'b0);
        bdest[1] = 1'b1;
        run_packet(0, tmo);
        total++;
        if (tmo !== 1'b0 || got_addr.size() != 3 || o_err !== 1'b1 || int'(o_len) != 12) begin
            bad++; $display("FAIL err_tdest nwr=%0d err=%b len=%0d want 3 1 12", got_addr.size(), o_err, o_len);
        end
        fill_pkt(3, 1'b1, 1'b0);
        bkeep[0] = 4'b0111;
        run_packet(0, tmo);
        total++;
        if (tmo !== 1'b0 || got_addr.size() != 3 || o_err !== 1'b1 || int'(o_len) != 11) begin
            bad++; $display("FAIL err_keep nwr=%0d err=%b len=%0d want 3 1 11", got_addr.size(), o_err, o_len);
        end
    endtask

    task automatic test_mid_reset();
        logic tmo;
        int   start;
        start = done_cnt;
        wr_ready = 1'b1;
        s_axis_tkeep = 4'hF;
        s_axis_tstrb = 4'hF;
        s_axis_tlast = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = $urandom;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (s_axis_tready !== 1'b0 || wr_en !== 1'b0) begin
            bad++; $display("FAIL midrst_ready tready=%b wr_en=%b want 0 0", s_axis_tready, wr_en);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_axis_tvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (done_cnt != start) begin bad++; $display("FAIL midrst_no_done got=%0d pulses want=0", done_cnt - start); end
        fill_pkt(2, 1'b0, 1'b0);
        bkeep[1] = 4'b0111;
        run_packet(0, tmo);
        total++;
        if (tmo !== 1'b0 || got_addr.size() != 2 || (got_addr.size() > 0 && got_addr[0] != 0)) begin
            bad++; $display("FAIL midrst_restart nwr=%0d timeout=%b want 2 writes from addr 0", got_addr.size(), tmo);
        end
        total++;
        if (int'(o_len) != 7 || o_err !== 1'b0) begin
            bad++; $display("FAIL midrst_report len=%0d err=%b want 7 0", o_len, o_err);
        end
    endtask

    task automatic test_random();
        logic tmo;
        logic base_tid;
        logic base_dest;
        for (int p = 0; p < 40; p++) begin
            base_tid  = 1'($urandom_range(0, 1));
            base_dest = 1'($urandom_range(0, 1));
            fill_pkt($urandom_range(1, 6), base_tid, base_dest);
            for (int i = 0; i < nb; i++) begin
                bstrb[i] = 4'($urandom);
                if (i == nb - 1 || $urandom_range(0, 9) == 0) bkeep[i] = 4'($urandom);
                if ($urandom_range(0, 14) == 0) btid[i]  = ~base_tid;
                if ($urandom_range(0, 14) == 0) bdest[i] = ~base_dest;
            end
            model_pkt();
            run_packet(2, tmo);
            total++;
            if (tmo !== 1'b0 || got_addr.size() != e_nwr) begin
                bad++; $display("FAIL rnd%0d_nwr got=%0d timeout=%b want %0d 0", p, got_addr.size(), tmo, e_nwr);
            end
            for (int i = 0; i < got_addr.size() && i < e_nwr; i++) begin
                total++;
                if (got_addr[i] != i || got_data[i] !== bdata[i] || got_strb[i] !== (bkeep[i] & bstrb[i])) begin
                    bad++; $display("FAIL rnd%0d_write%0d addr=%0d data=%h strb=%b want %0d %h %b",
                                    p, i, got_addr[i], got_data[i], got_strb[i], i, bdata[i], bkeep[i] & bstrb[i]);
                end
            end
            total++;
            if (int'(o_len) != e_len || o_err !== e_err || o_id !== btid[0] || o_dest !== bdest[0]) begin
                bad++; $display("FAIL rnd%0d_report len=%0d err=%b id=%b dest=%b want %0d %b %b %b",
                                p, o_len, o_err, o_id, o_dest, e_len, e_err, btid[0], bdest[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_beat();
        test_single_beat();
        test_backpressure();
        test_overflow();
        test_errors();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
